// File: rtl/scrisc_fetch_unit.sv
// scrisc_fetch_unit
//   Decoupled instruction-fetch front end. Issues fetches on a handshaked
//   instruction-memory port and buffers responses in an in-order prefetch
//   queue. Redirects flush the queue and discard in-flight responses. Decode
//   receives each instruction with its PC and PC+PC_STEP (link value).
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   imem_req/addr/gnt      fetch request (issue = imem_req & imem_gnt)
//   imem_rvalid/rdata      in-order, unstallable responses
//   redirect_valid/pc      branch/jump taken: flush and refetch from pc
//   instr_valid/instr      queue head toward decode
//   instr_pc/pcincr        PC of head and PC + PC_STEP
//   instr_ready            decode pops head (instr_valid & instr_ready)
module scrisc_fetch_unit #(
    parameter int              XLEN     = 16,
    parameter int              ILEN     = 16,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcincr,
    input  logic            instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   LP_DEPTH = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] LP_STEP = XLEN'(PC_STEP);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fpc;
    logic [CW-1:0]   r_outst, r_disc, r_cnt;
    logic [AW-1:0]   r_head, r_tail, r_shead, r_stail;
    logic [ILEN-1:0] r_qi  [DEPTH];
    logic [XLEN-1:0] r_qpc [DEPTH];
    logic [XLEN-1:0] r_spc [DEPTH];   // issue-PC shadow, one entry per outstanding fetch

    logic [CW:0] w_occ;
    logic        w_issue, w_push, w_pop;

    // Slots already claimed: buffered entries plus fetches whose data will be kept.
    // Keeping this below DEPTH guarantees every kept response has a free slot.
    assign w_occ    = (CW+1)'(r_cnt) + (CW+1)'(r_outst) - (CW+1)'(r_disc);
    assign imem_req = (r_state == S_RUN) && (w_occ < LP_DEPTH) && ((CW+1)'(r_outst) < LP_DEPTH);
    assign imem_addr = r_fpc;
    assign w_issue  = imem_req & imem_gnt;
    assign w_push   = imem_rvalid & (r_disc == '0);
    assign w_pop    = instr_valid & instr_ready;

    assign instr_valid  = (r_cnt != '0);
    assign instr        = r_qi[r_head];
    assign instr_pc     = r_qpc[r_head];
    assign instr_pcincr = r_qpc[r_head] + LP_STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_fpc   <= RESET_PC;
            r_outst <= '0;
            r_disc  <= '0;
            r_cnt   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_shead <= '0;
            r_stail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_qi[i]  <= '0;
                r_qpc[i] <= '0;
                r_spc[i] <= '0;
            end
        end else begin
            r_state <= S_RUN;

            // Shadow queue tracks every fetch on the bus, kept or discarded,
            // so it is never affected by redirects.
            if (w_issue) begin
                r_spc[r_stail] <= r_fpc;
                r_stail        <= r_stail + AW'(1);
            end
            if (imem_rvalid)
                r_shead <= r_shead + AW'(1);
            r_outst <= r_outst + CW'(w_issue) - CW'(imem_rvalid);

            if (redirect_valid) begin
                // Everything still on the bus after this edge is stale,
                // including a fetch granted right now.
                r_fpc  <= redirect_pc;
                r_disc <= r_outst + CW'(w_issue) - CW'(imem_rvalid);
                r_cnt  <= '0;
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_issue)
                    r_fpc <= r_fpc + LP_STEP;
                if (imem_rvalid && r_disc != '0)
                    r_disc <= r_disc - CW'(1);
                if (w_push) begin
                    r_qi[r_tail]  <= imem_rdata;
                    r_qpc[r_tail] <= r_spc[r_shead];
                    r_tail        <= r_tail + AW'(1);
                end
                if (w_pop)
                    r_head <= r_head + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_scrisc_fetch_unit.sv
// tb_scrisc_fetch_unit
//   Scoreboarded bench: every granted fetch that is not killed by a redirect
//   is queued as an expected delivery; every pop is compared against it.
//   A second instance with RESET_PC=0xFFFC runs a 1-cycle memory for wrap.
module tb_scrisc_fetch_unit;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        reset = 1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, imem_rdata;
    logic        redirect_valid, instr_valid, instr_ready;
    logic [15:0] redirect_pc, instr, instr_pc, instr_pcincr;

    scrisc_fetch_unit u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pcincr(instr_pcincr), .instr_ready(instr_ready)
    );

    // wrap-around instance: always grant, 1-cycle memory, always ready
    logic        req2, rv2, v2;
    logic [15:0] addr2, rd2, i2, pc2, inc2;
    logic        one = 1'b1, zero = 1'b0;
    logic [15:0] zpc = 16'h0;

    scrisc_fetch_unit #(.RESET_PC(16'hFFFC)) u_dut2 (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(one),
        .imem_rvalid(rv2), .imem_rdata(rd2),
        .redirect_valid(zero), .redirect_pc(zpc),
        .instr_valid(v2), .instr(i2), .instr_pc(pc2),
        .instr_pcincr(inc2), .instr_ready(one)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rv2 <= 1'b0;
            rd2 <= '0;
        end else begin
            rv2 <= req2;
            rd2 <= addr2 ^ 16'hA5A5;
        end
    end

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] pc, inc, ins; } d2_t;

    mreq_t       memq[$];
    logic [15:0] expq[$], iss_log[$], pop_log[$];
    d2_t         log2[$];
    int          cyc, lat, n_chk, n_fail, first_req, first_val;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
        memq.delete(); expq.delete(); iss_log.delete(); pop_log.delete(); log2.delete();
        first_req = -1; first_val = -1;
        repeat (2) @(posedge clk);
        #2 reset = 1;
        cyc = 0;
    endtask

    // One cycle: drive at negedge, sample 1ns later, account for the coming edge.
    task automatic step(input logic rdy, input logic gnt,
                        input logic redir = 1'b0, input logic [15:0] rpc = 16'h0);
        logic [15:0] e;
        mreq_t m;
        @(negedge clk);
        instr_ready = rdy; imem_gnt = gnt; redirect_valid = redir; redirect_pc = rpc;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rvalid = 1; imem_rdata = m.addr ^ 16'hA5A5;
        end else begin
            imem_rvalid = 0; imem_rdata = 0;
        end
        #1;
        if (imem_req && first_req < 0) first_req = cyc;
        if (instr_valid && first_val < 0) first_val = cyc;
        if (v2) log2.push_back('{pc2, inc2, i2});
        if (instr_valid && rdy && !redir) begin
            pop_log.push_back(instr_pc);
            if (expq.size() == 0)
                chk("spurious_pop", 16'(expq.size()), 16'd1);
            else begin
                e = expq.pop_front();
                chk("head_pc", instr_pc, e);
                chk("head_instr", instr, e ^ 16'hA5A5);
                chk("head_pcincr", instr_pcincr, e + 16'd2);
            end
        end
        if (redir) expq.delete();
        if (imem_req && gnt) begin
            memq.push_back('{imem_addr, cyc + lat});
            iss_log.push_back(imem_addr);
            if (!redir) expq.push_back(imem_addr);
        end
        cyc++;
    endtask

    task automatic drain();
        repeat (lat + 6) step(1, 0);
        chk("drain_sb_empty", 16'(expq.size()), 16'd0);
        chk("drain_valid", 16'(instr_valid), 16'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; lat = 1;
        #1 reset = 0;
        #1;
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_pcincr", instr_pcincr, 16'h0002);
        chk("rst2_addr", addr2, 16'hFFFC);

        // stream, 1-cycle memory
        do_reset();
        repeat (20) step(1, 1);
        chk("first_req_cycle", 16'(first_req), 16'd1);
        chk("first_valid_cycle", 16'(first_val), 16'd3);
        chk("stream_pops", 16'(pop_log.size()), 16'd17);
        chk("stream_pc0", pop_log[0], 16'h0000);
        chk("stream_pc1", pop_log[1], 16'h0002);
        chk("wrap_pc0", log2[0].pc, 16'hFFFC);
        chk("wrap_ins0", log2[0].ins, 16'hFFFC ^ 16'hA5A5);
        chk("wrap_pc1", log2[1].pc, 16'hFFFE);
        chk("wrap_inc1", log2[1].inc, 16'h0000);
        chk("wrap_pc2", log2[2].pc, 16'h0000);
        drain();

        // backpressure until full, then release
        do_reset();
        repeat (10) step(0, 1);
        chk("full_issues", 16'(iss_log.size()), 16'd4);
        chk("full_last_addr", iss_log[3], 16'h0006);
        chk("full_req_low", 16'(imem_req), 16'd0);
        repeat (12) step(1, 1);
        chk("resume_addr", iss_log[4], 16'h0008);
        chk("resume_pop4", pop_log[4], 16'h0008);
        drain();

        // redirect with three in flight plus a same-cycle grant, 3-cycle memory
        lat = 3;
        do_reset();
        repeat (4) step(1, 1);
        step(1, 1, 1, 16'h0100);
        chk("redir_req_same_cycle", 16'(imem_req), 16'd1);
        chk("redir_rvalid_same_cycle", 16'(imem_rvalid), 16'd1);
        step(1, 1);
        chk("redir_addr_next", imem_addr, 16'h0100);
        chk("redir_valid_next", 16'(instr_valid), 16'd0);
        repeat (20) step(1, 1);
        chk("redir_first_pc", pop_log[0], 16'h0100);
        chk("redir_second_pc", pop_log[1], 16'h0102);
        drain();
        lat = 1;

        // redirect and pop in the same cycle with three buffered entries
        do_reset();
        repeat (5) step(0, 1);
        step(1, 1, 1, 16'h0200);
        chk("rp_valid_before", 16'(instr_valid), 16'd1);
        step(1, 1);
        chk("rp_valid_after", 16'(instr_valid), 16'd0);
        repeat (10) step(1, 1);
        chk("rp_first_pc", pop_log[0], 16'h0200);
        drain();

        // asynchronous reset with two buffered entries
        do_reset();
        repeat (4) step(0, 1);
        @(posedge clk);
        #2;
        chk("ar_valid_before", 16'(instr_valid), 16'd1);
        reset = 0;
        #1;
        chk("ar_valid_dropped", 16'(instr_valid), 16'd0);
        chk("ar_req_dropped", 16'(imem_req), 16'd0);
        chk("ar_addr_reset", imem_addr, 16'h0000);
        do_reset();
        repeat (8) step(1, 1);
        chk("ar_restart_addr", iss_log[0], 16'h0000);
        chk("ar_restart_pc", pop_log[0], 16'h0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
